// File: rtl/ks_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
package ks_pkg;
  localparam int WIDTH_DEF = 32;

  function automatic int levels_f(input int w);
    return $clog2(w);
  endfunction

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Prefix combine: higher-order span absorbs the lower-order one.
  function automatic gp_t carry_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction
endpackage

// File: rtl/ks_prefix_stage.sv
// One registered Kogge-Stone prefix level with its valid bit and sideband.
module ks_prefix_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vld,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] p0,
  input  logic             xs,
  input  logic             ys,
  output logic             vld_q,
  output logic [WIDTH-1:0] g_q,
  output logic [WIDTH-1:0] p_q,
  output logic [WIDTH-1:0] p0_q,
  output logic             xs_q,
  output logic             ys_q
);
  logic [WIDTH-1:0] gn, pn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      gp_t hi, lo;
      assign hi = {g[i], p[i]};
      assign lo = {g[i-DIST], p[i-DIST]};
      assign {gn[i], pn[i]} = carry_op(hi, lo);
    end else begin : g_pass
      assign gn[i] = g[i];
      assign pn[i] = p[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      g_q   <= '0;
      p_q   <= '0;
      p0_q  <= '0;
      xs_q  <= 1'b0;
      ys_q  <= 1'b0;
    end else if (en) begin
      vld_q <= vld;
      g_q   <= gn;
      p_q   <= pn;
      p0_q  <= p0;
      xs_q  <= xs;
      ys_q  <= ys;
    end
  end
endmodule

// File: rtl/ks_sub_pipe.sv
// Pipelined Kogge-Stone subtractor (x + ~y + 1) with borrow/zero/overflow flags
// on valid/ready streams; the whole pipeline stalls together on backpressure.
module ks_sub_pipe
  import ks_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  localparam int LEVELS = levels_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);
  logic adv, acc;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign acc      = in_valid & adv;

  logic [LEVELS:0][WIDTH-1:0] g_s, p_s, p0_s;
  logic [LEVELS:0]            xs_s, ys_s;
  logic [LEVELS+1:0]          vld_pipe;

  // Stage 0: bitwise generate/propagate against the inverted subtrahend.
  logic             v0_q, xs0_q, ys0_q;
  logic [WIDTH-1:0] g0_q, p0_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      g0_q  <= '0;
      p0_q  <= '0;
      xs0_q <= 1'b0;
      ys0_q <= 1'b0;
    end else if (adv) begin
      v0_q  <= acc;
      g0_q  <= x & ~y;
      p0_q  <= x ^ ~y;
      xs0_q <= x[WIDTH-1];
      ys0_q <= y[WIDTH-1];
    end
  end

  assign vld_pipe[0] = v0_q;
  assign g_s[0]      = g0_q;
  assign p_s[0]      = p0_q;
  assign p0_s[0]     = p0_q;
  assign xs_s[0]     = xs0_q;
  assign ys_s[0]     = ys0_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    ks_prefix_stage #(.WIDTH(WIDTH), .DIST(1 << (k - 1))) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .vld   (vld_pipe[k-1]),
      .g     (g_s[k-1]),
      .p     (p_s[k-1]),
      .p0    (p0_s[k-1]),
      .xs    (xs_s[k-1]),
      .ys    (ys_s[k-1]),
      .vld_q (vld_pipe[k]),
      .g_q   (g_s[k]),
      .p_q   (p_s[k]),
      .p0_q  (p0_s[k]),
      .xs_q  (xs_s[k]),
      .ys_q  (ys_s[k])
    );
  end

  assign vld_pipe[LEVELS+1] = out_valid;

  // Output stage: carry-in of 1 makes the prefix span (g|p) the carry into each bit.
  logic [WIDTH-1:0] c, d_nxt;
  logic             cout;

  always_comb begin
    c     = {g_s[LEVELS][WIDTH-2:0] | p_s[LEVELS][WIDTH-2:0], 1'b1};
    d_nxt = p0_s[LEVELS] ^ c;
    cout  = g_s[LEVELS][WIDTH-1] | p_s[LEVELS][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_pipe[LEVELS];
      d         <= d_nxt;
      borrow    <= ~cout;
      zero      <= ~|d_nxt;
      ovf       <= (xs_s[LEVELS] ^ ys_s[LEVELS]) & (xs_s[LEVELS] ^ d_nxt[WIDTH-1]);
    end
  end
endmodule

// File: tb/tb_ks_sub_pipe.sv
// Self-checking bench for ks_sub_pipe: directed vectors, streaming with stalls, reset mid-stream.
module tb_ks_sub_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x, y, d;
  logic         borrow, zero, ovf;

  always #5 clk = ~clk;

  ks_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         b, z, o;
  } res_t;

  typedef struct packed {
    logic [W-1:0] x, y;
    res_t         e;
  } vec_t;

  int   total = 0, bad = 0, n_pop = 0;
  bit   use_model = 1'b0;
  res_t nxt_exp;
  res_t exp_q[$];

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   r;
    longint sd;
    sd  = longint'(signed'(a)) - longint'(signed'(b));
    r.d = a - b;
    r.b = (a < b);
    r.z = (a == b);
    r.o = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge after inputs are set; scores the output and input handshakes.
  task automatic step();
    res_t e;
    #1;
    if (out_valid && out_ready) begin
      chk("out_expected", W'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        chk("d", d, e.d);
        chk("borrow", W'(borrow), W'(e.b));
        chk("zero", W'(zero), W'(e.z));
        chk("ovf", W'(ovf), W'(e.o));
      end
    end
    if (in_valid && in_ready) exp_q.push_back(use_model ? model(x, y) : nxt_exp);
    @(negedge clk);
  endtask

  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
    int lat;
    use_model = 1'b0;
    nxt_exp   = e;
    x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; x = $urandom; y = $urandom;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 7);
    step();
    chk("single_cycle", W'(out_valid), 0);
  endtask

  vec_t         tv[7];
  logic [W-1:0] sx[16], sy[16];
  res_t         snap;

  initial begin
    int idx, stall_left, guard, cnt;
    tv[0] = '{x: 32'd5,          y: 32'd3,          e: '{d: 32'd2,          b: 0, z: 0, o: 0}};
    tv[1] = '{x: 32'd3,          y: 32'd5,          e: '{d: 32'hFFFFFFFE,   b: 1, z: 0, o: 0}};
    tv[2] = '{x: 32'h80000000,   y: 32'd1,          e: '{d: 32'h7FFFFFFF,   b: 0, z: 0, o: 1}};
    tv[3] = '{x: 32'h7FFFFFFF,   y: 32'hFFFFFFFF,   e: '{d: 32'h80000000,   b: 1, z: 0, o: 1}};
    tv[4] = '{x: 32'hDEADBEEF,   y: 32'hDEADBEEF,   e: '{d: 32'd0,          b: 0, z: 1, o: 0}};
    tv[5] = '{x: 32'd0,          y: 32'd0,          e: '{d: 32'd0,          b: 0, z: 1, o: 0}};
    tv[6] = '{x: 32'd0,          y: 32'd1,          e: '{d: 32'hFFFFFFFF,   b: 1, z: 0, o: 0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_d", d, 0);
    chk("rst_flags", {29'd0, borrow, zero, ovf}, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", W'(in_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) single_op(tv[i].x, tv[i].y, tv[i].e);

    // Back-to-back stream with a 4-cycle stall after the first result.
    use_model = 1'b1;
    for (int i = 0; i < 16; i++) begin sx[i] = $urandom; sy[i] = $urandom; end
    sx[3] = sy[3];
    idx = 0; stall_left = -1; guard = 0; cnt = n_pop;
    while ((idx < 16 || exp_q.size() > 0) && guard < 200) begin
      guard++;
      in_valid = (idx < 16);
      if (idx < 16) begin x = sx[idx]; y = sy[idx]; end
      if (stall_left < 0 && n_pop > cnt) stall_left = 4;
      out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        chk("stall_in_ready", W'(in_ready), 0);
        if (stall_left == 4) snap = '{d: d, b: borrow, z: zero, o: ovf};
        else begin
          chk("stall_d_stable", d, snap.d);
          chk("stall_flags_stable", {29'd0, borrow, zero, ovf}, {29'd0, snap.b, snap.z, snap.o});
          chk("stall_valid_stable", W'(out_valid), 1);
        end
      end else if (idx < 16) chk("run_in_ready", W'(in_ready), 1);
      if (in_valid && in_ready) idx++;
      step();
      if (stall_left > 0) stall_left--;
    end
    chk("stream_count", n_pop - cnt, 16);
    chk("stream_guard", W'(guard < 200), 1);

    // Random valid/ready traffic.
    idx = 0; guard = 0; cnt = n_pop;
    while ((idx < 40 || exp_q.size() > 0) && guard < 600) begin
      guard++;
      if (!(in_valid && idx < 40)) begin x = $urandom; y = $urandom; end
      in_valid  = (idx < 40) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    chk("random_count", n_pop - cnt, 40);

    // Reset with four operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_out_valid", W'(out_valid), 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_flags", {29'd0, borrow, zero, ovf}, 0);
    rst_n = 1'b1;
    #1 chk("mid_rst_in_ready", W'(in_ready), 1);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cnt++;
      step();
    end
    chk("no_stale", cnt, 0);
    single_op(32'd9, 32'd4, '{d: 32'd5, b: 0, z: 0, o: 0});

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ks_sub_pipe.md
Name: ks_sub_pipe

Overview:
Pipelined Kogge-Stone subtractor. It computes D = X - Y as X + ~Y + 1 using the same generate/propagate prefix network as the combinational Kogge-Stone adder, with a register after every prefix level. It sits on valid/ready streams between operand producers and compare/branch consumers. Besides the difference, it reports unsigned borrow, zero and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two, minimum 2.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, never overridden.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- in_valid, input, 1, x/y are valid this cycle.
- in_ready, output, 1, block accepts x/y this cycle.
- x, input, WIDTH, minuend.
- y, input, WIDTH, subtrahend.
- out_valid, output, 1, result fields are valid.
- out_ready, input, 1, consumer accepts the result.
- d, output, WIDTH, x - y modulo 2^WIDTH.
- borrow, output, 1, 1 when x < y (unsigned); equals ~carry_out.
- zero, output, 1, 1 when d == 0.
- ovf, output, 1, signed overflow: (x[msb]^y[msb]) & (x[msb]^d[msb]).

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valid bits, all stage data registers, out_valid, d, borrow, zero and ovf are cleared to 0. In-flight operations are discarded. in_ready reads 1 in the first cycle after release.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - Every pipeline register, valid bits included, loads only when adv=1.
  - When adv=0 the whole pipeline holds, and d/borrow/zero/ovf/out_valid stay stable.
  - Bubbles are not compressed while stalled.
- Accept: in_valid & in_ready.
- Stage 0 (GP): registers G0[i] = x[i] & ~y[i], P0[i] = x[i] ^ ~y[i], plus x[msb] and y[msb]. The stage valid bit is set to the accept value.
- Stages 1..LEVELS (prefix): level k uses dist = 2^(k-1).
  - For i >= dist: (G,P)[i] = (G[i] | (P[i] & G[i-dist]), P[i] & P[i-dist]).
  - For i < dist: pass through unchanged.
  - P0 and the sign bits are carried alongside unchanged.
- Output stage (LEVELS+1): carry-in is fixed at 1.
  - c[0] = 1; c[i] = G[i-1] | P[i-1] for i >= 1.
  - d[i] = P0[i] ^ c[i].
  - carry_out = G[WIDTH-1] | P[WIDTH-1].
  - borrow = ~carry_out; zero = ~|d; ovf as defined under Ports.
  - All four fields are registered, with out_valid.
- Latency: LEVELS+2 cycles from accept to out_valid with out_ready held at 1 (7 for WIDTH=32). Throughput is 1 result per cycle.
- Order: results leave strictly in acceptance order. No drop and no duplication under any out_ready pattern.
- Simultaneous accept and output handshake in one cycle is legal and required for full throughput.
- in_valid=1 while in_ready=0: x/y are ignored; the producer must hold them.
- Boundary cases:
  - x = y gives d=0, zero=1, borrow=0.
  - x=0, y=0 gives borrow=0.
  - x=0, y=1 gives d=all ones, borrow=1.
  - Most-negative minus 1 gives ovf=1.
- X/unknown inputs while in_valid=0 must not propagate into valid outputs.

Decomposition:
- Package ks_pkg holds:
  - the WIDTH default constant;
  - the function for LEVELS;
  - a packed struct gp_t {g, p} per bit;
  - a function carry_op(gp_hi, gp_lo) returning (g_hi | p_hi & g_lo, p_hi & p_lo).
- One sub-module: ks_prefix_stage (parameters WIDTH, DIST).
  - It contains one prefix level, its register with enable, its valid bit and the sideband (P0, sign bits).
  - The top instantiates it LEVELS times in a generate loop.
  - The GP and output stages stay in the top.

Test Plan:
- x=5, y=3, out_ready=1 -> 7 cycles later d=2, borrow=0, zero=0, ovf=0, out_valid for exactly 1 cycle.
- x=3, y=5 -> d=0xFFFFFFFE, borrow=1, zero=0, ovf=0.
- x=0x80000000, y=1 -> d=0x7FFFFFFF, ovf=1, borrow=0. Also x=0x7FFFFFFF, y=0xFFFFFFFF -> d=0x80000000, ovf=1, borrow=1.
- x=y=0xDEADBEEF -> d=0, zero=1, borrow=0, ovf=0.
- Streaming with backpressure: 16 back-to-back random pairs, out_ready=0 for 4 cycles after the first result -> all 16 results match a reference model, in order, outputs stable while stalled, in_ready=0 exactly during the stall.
- Reset mid-stream: rst_n=0 for 1 cycle with 4 operations in flight -> out_valid=0 and d/borrow/zero/ovf=0 next cycle. No stale results appear after release. A new pair (9, 4) then yields d=5 after 7 cycles.
